// File: rtl/ref_block_fetcher_if.sv
// rtl/ref_block_fetcher_if.sv - handshake and memory-read bundle for ref_block_fetcher (REF_FETCH_PERF_EN adds out_stall_cycles)
interface ref_block_fetcher_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int MEMORY_DEPTH = 256,
  parameter int WIN_W        = 16,
  parameter int BLK_W        = 4
);
  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int CW = ((WIN_W - BLK_W + 1) > 1) ? $clog2(WIN_W - BLK_W + 1) : 1;
  localparam int RW = (BLK_W > 1) ? $clog2(BLK_W) : 1;

  logic                  in_start;
  logic                  in_mem_busy;
  logic [AW-1:0]         out_read_addr;
  logic [DATA_WIDTH-1:0] in_read_data;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic                  out_valid;
  logic                  in_ready;
  logic [CW-1:0]         out_cand_x;
  logic [CW-1:0]         out_cand_y;
  logic [RW-1:0]         out_row;
  logic [RW-1:0]         out_col;
  logic                  out_blk_last;
  logic                  out_busy;
  logic                  out_done;
`ifdef REF_FETCH_PERF_EN
  logic [31:0]           out_stall_cycles;
`endif

  modport master (
    input  in_start, in_mem_busy, in_read_data, in_ready,
    output out_read_addr, out_pixel, out_valid, out_cand_x, out_cand_y,
    output out_row, out_col, out_blk_last, out_busy, out_done
`ifdef REF_FETCH_PERF_EN
    , output out_stall_cycles
`endif
  );

  modport slave (
    output in_start, in_mem_busy, in_read_data, in_ready,
    input  out_read_addr, out_pixel, out_valid, out_cand_x, out_cand_y,
    input  out_row, out_col, out_blk_last, out_busy, out_done
`ifdef REF_FETCH_PERF_EN
    , input out_stall_cycles
`endif
  );
endinterface

// File: rtl/ref_block_fetcher.sv
// rtl/ref_block_fetcher.sv - search-window block read sequencer feeding the SAD engine (optional REF_FETCH_PERF_EN stall counter)
module ref_block_fetcher #(
  parameter int DATA_WIDTH   = 8,
  parameter int MEMORY_DEPTH = 256,
  parameter int WIN_W        = 16,
  parameter int BLK_W        = 4
) (
  input logic                  in_clk,
  input logic                  in_rst_n,
  ref_block_fetcher_if.master  bus
);
  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int NC = WIN_W - BLK_W + 1;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int RW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(NC - 1);
  localparam logic [RW-1:0] P_MAX = RW'(BLK_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  // element pointer: next element to be issued
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  // tags of the beat currently on the output
  logic [CW-1:0] tcx_q, tcx_d, tcy_q, tcy_d;
  logic [RW-1:0] trow_q, trow_d, tcol_q, tcol_d;
  logic          valid_q, valid_d;
  // address of the displayed beat, re-presented while it is held
  logic [AW-1:0] disp_q, disp_d;

  logic [AW:0]   addr_full;
  logic [AW-1:0] elem_addr;
  logic          issue;
  logic          last_elem;

  assign addr_full = ((AW+1)'(cy_q) + (AW+1)'(row_q)) * (AW+1)'(WIN_W)
                   + (AW+1)'(cx_q) + (AW+1)'(col_q);
  assign elem_addr = addr_full[AW-1:0];
  assign issue     = (state_q == S_RUN) && !bus.in_mem_busy && (!valid_q || bus.in_ready);
  assign last_elem = (cx_q == C_MAX) && (cy_q == C_MAX) && (row_q == P_MAX) && (col_q == P_MAX);

  // next-state, element pointer advance and output beat register update
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    row_d   = row_q;
    col_d   = col_q;
    tcx_d   = tcx_q;
    tcy_d   = tcy_q;
    trow_d  = trow_q;
    tcol_d  = tcol_q;
    valid_d = valid_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_start) begin
          state_d = S_RUN;
          cx_d    = '0;
          cy_d    = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN:   if (issue && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (valid_q && bus.in_ready) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      valid_d = 1'b1;
      tcx_d   = cx_q;
      tcy_d   = cy_q;
      trow_d  = row_q;
      tcol_d  = col_q;
      disp_d  = elem_addr;
      // col -> row -> cand_x -> cand_y carry chain resolves in one cycle
      if (col_q == P_MAX) begin
        col_d = '0;
        if (row_q == P_MAX) begin
          row_d = '0;
          if (cx_q == C_MAX) begin
            cx_d = '0;
            cy_d = (cy_q == C_MAX) ? '0 : cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (valid_q && bus.in_ready) begin
      valid_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tcx_q   <= '0;
      tcy_q   <= '0;
      trow_q  <= '0;
      tcol_q  <= '0;
      valid_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tcx_q   <= tcx_d;
      tcy_q   <= tcy_d;
      trow_q  <= trow_d;
      tcol_q  <= tcol_d;
      valid_q <= valid_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.out_read_addr = issue ? elem_addr : disp_q;
  assign bus.out_pixel     = bus.in_read_data;
  assign bus.out_valid     = valid_q;
  assign bus.out_cand_x    = tcx_q;
  assign bus.out_cand_y    = tcy_q;
  assign bus.out_row       = trow_q;
  assign bus.out_col       = tcol_q;
  assign bus.out_blk_last  = valid_q && (trow_q == P_MAX) && (tcol_q == P_MAX);
  assign bus.out_busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.out_done      = (state_q == S_DONE);

`ifdef REF_FETCH_PERF_EN
  logic [31:0] stall_q;

  // saturating count of cycles lost to consumer back-pressure or memory writes
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && bus.in_start) begin
      stall_q <= '0;
    end else if (bus.out_busy && ((valid_q && !bus.in_ready) || (state_q == S_RUN && bus.in_mem_busy))
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.out_stall_cycles = stall_q;
`endif
endmodule
